// File: rtl/pe_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pe_stream_ctrl
//  Purpose  : Feeds one PE with config, filter, ifmap and ipsum words fetched
//             from a local buffer, and collects returned opsums.
//  Revision : 1.0
// ============================================================================
module pe_stream_ctrl #(
    parameter int ADDR_W      = 12,
    parameter int DATA_BITS   = 32,
    parameter int CONFIG_SIZE = 13
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CONFIG_SIZE-1:0] cfg,
    input  logic [ADDR_W-1:0]      filter_base,
    input  logic [ADDR_W-1:0]      ifmap_base,
    input  logic [ADDR_W-1:0]      ipsum_base,
    input  logic [ADDR_W-1:0]      opsum_base,
    output logic                   busy,
    output logic                   done,
    output logic                   rd_en,
    output logic [ADDR_W-1:0]      rd_addr,
    input  logic [DATA_BITS-1:0]   rd_data,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [DATA_BITS-1:0]   wr_data,
    output logic                   PE_en,
    output logic [CONFIG_SIZE-1:0] i_config,
    output logic [DATA_BITS-1:0]   filter,
    output logic                   filter_valid,
    input  logic                   filter_ready,
    output logic [DATA_BITS-1:0]   ifmap,
    output logic                   ifmap_valid,
    input  logic                   ifmap_ready,
    output logic [DATA_BITS-1:0]   depthwise_ipsum,
    output logic                   depthwise_ipsum_valid,
    input  logic                   depthwise_ipsum_ready,
    output logic [DATA_BITS-1:0]   pointwise_ipsum,
    output logic                   pointwise_ipsum_valid,
    input  logic                   pointwise_ipsum_ready,
    input  logic [DATA_BITS-1:0]   opsum,
    input  logic                   opsum_valid,
    output logic                   opsum_ready
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CFG    = 3'd1;
    localparam logic [2:0] S_FILTER = 3'd2;
    localparam logic [2:0] S_IFMAP  = 3'd3;
    localparam logic [2:0] S_IPSUM  = 3'd4;
    localparam logic [2:0] S_PIPSUM = 3'd5;
    localparam logic [2:0] S_OPSUM  = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    logic [2:0]             state_q, state_d;
    logic [CONFIG_SIZE-1:0] cfg_q, cfg_d;
    logic [ADDR_W-1:0]      fbase_q, fbase_d, ibase_q, ibase_d;
    logic [ADDR_W-1:0]      pbase_q, pbase_d, obase_q, obase_d;
    logic [4:0]             col_q, col_d, rd_cnt_q, rd_cnt_d, tx_cnt_q, tx_cnt_d;
    logic [DATA_BITS-1:0]   hold_q, hold_d;
    logic                   hold_vld_q, hold_vld_d, pend_q, pend_d;

    logic                   dw;
    logic [4:0]             p_n, q_n, r_n, total;
    logic [ADDR_W-1:0]      p_a, q_a, r_a, col_a, cw, rd_addr_w;
    logic                   send_st, ready_cur, out_vld, hs, issue, last_hs, wr_fire;
    logic [DATA_BITS-1:0]   out_word;

    assign dw    = cfg_q[12];
    assign p_n   = 5'(cfg_q[8:7]) + 5'd1;
    assign q_n   = 5'(cfg_q[1:0]) + 5'd1;
    assign r_n   = 5'(cfg_q[11:10]) + 5'd1;
    assign p_a   = ADDR_W'(p_n);
    assign q_a   = ADDR_W'(q_n);
    assign r_a   = ADDR_W'(r_n);
    assign col_a = ADDR_W'(col_q);
    // Per-column ipsum stride: depthwise columns also carry 4 pointwise words.
    assign cw    = col_a * (dw ? (q_a + ADDR_W'(4)) : p_a);

    always_comb begin
        total     = 5'd0;
        ready_cur = 1'b0;
        rd_addr_w = '0;
        case (state_q)
            S_FILTER: begin
                total     = p_n * r_n;
                ready_cur = filter_ready;
                rd_addr_w = fbase_q + ADDR_W'(rd_cnt_q);
            end
            S_IFMAP: begin
                total     = (col_q == 5'd0) ? r_n : 5'd1;
                ready_cur = ifmap_ready;
                rd_addr_w = (col_q == 5'd0) ? ibase_q + ADDR_W'(rd_cnt_q)
                                            : ibase_q + r_a + col_a - ADDR_W'(1);
            end
            S_IPSUM: begin
                total     = dw ? q_n : p_n;
                ready_cur = depthwise_ipsum_ready;
                rd_addr_w = pbase_q + cw + ADDR_W'(rd_cnt_q);
            end
            S_PIPSUM: begin
                total     = 5'd4;
                ready_cur = pointwise_ipsum_ready;
                rd_addr_w = pbase_q + cw + q_a + ADDR_W'(rd_cnt_q);
            end
            default: ;
        endcase
    end

    // The output word is either the held word or the read landing this cycle,
    // which lets a refill overlap a handshake for one word per cycle.
    assign send_st  = (state_q == S_FILTER) || (state_q == S_IFMAP) ||
                      (state_q == S_IPSUM)  || (state_q == S_PIPSUM);
    assign out_vld  = send_st && (hold_vld_q || pend_q);
    assign out_word = hold_vld_q ? hold_q : rd_data;
    assign hs       = out_vld && ready_cur;
    assign issue    = send_st && (rd_cnt_q < total) && (!out_vld || hs);
    assign last_hs  = hs && (tx_cnt_q == total - 5'd1);
    assign wr_fire  = (state_q == S_OPSUM) && opsum_valid;

    always_comb begin
        logic phase_end;
        phase_end  = 1'b0;
        state_d    = state_q;
        cfg_d      = cfg_q;
        fbase_d    = fbase_q;
        ibase_d    = ibase_q;
        pbase_d    = pbase_q;
        obase_d    = obase_q;
        col_d      = col_q;
        rd_cnt_d   = rd_cnt_q + (issue ? 5'd1 : 5'd0);
        tx_cnt_d   = tx_cnt_q + (hs ? 5'd1 : 5'd0);
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        pend_d     = issue;
        if (pend_q && !hs) begin
            hold_d     = rd_data;
            hold_vld_d = 1'b1;
        end else if (hs) begin
            hold_vld_d = 1'b0;
        end
        case (state_q)
            S_IDLE: if (start) begin
                cfg_d   = cfg;
                fbase_d = filter_base;
                ibase_d = ifmap_base;
                pbase_d = ipsum_base;
                obase_d = opsum_base;
                col_d   = 5'd0;
                state_d = S_CFG;
            end
            S_CFG: begin
                state_d   = S_FILTER;
                phase_end = 1'b1;
            end
            S_FILTER: if (last_hs) begin
                state_d   = S_IFMAP;
                phase_end = 1'b1;
            end
            S_IFMAP: if (last_hs) begin
                state_d   = S_IPSUM;
                phase_end = 1'b1;
            end
            S_IPSUM: if (last_hs) begin
                state_d   = dw ? S_PIPSUM : S_OPSUM;
                phase_end = 1'b1;
            end
            S_PIPSUM: if (last_hs) begin
                state_d   = S_OPSUM;
                phase_end = 1'b1;
            end
            S_OPSUM: if (wr_fire) begin
                tx_cnt_d = tx_cnt_q + 5'd1;
                if (tx_cnt_q == p_n - 5'd1) begin
                    phase_end = 1'b1;
                    if (col_q == cfg_q[6:2]) begin
                        state_d = S_DONE;
                    end else begin
                        col_d   = col_q + 5'd1;
                        state_d = S_IFMAP;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (phase_end) begin
            rd_cnt_d = 5'd0;
            tx_cnt_d = 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cfg_q      <= '0;
            fbase_q    <= '0;
            ibase_q    <= '0;
            pbase_q    <= '0;
            obase_q    <= '0;
            col_q      <= '0;
            rd_cnt_q   <= '0;
            tx_cnt_q   <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            fbase_q    <= fbase_d;
            ibase_q    <= ibase_d;
            pbase_q    <= pbase_d;
            obase_q    <= obase_d;
            col_q      <= col_d;
            rd_cnt_q   <= rd_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            pend_q     <= pend_d;
        end
    end

    assign busy                  = (state_q != S_IDLE);
    assign done                  = (state_q == S_DONE);
    assign PE_en                 = (state_q == S_CFG);
    assign i_config              = cfg_q;
    assign rd_en                 = issue;
    assign rd_addr               = issue ? rd_addr_w : '0;
    assign opsum_ready           = (state_q == S_OPSUM);
    assign wr_en                 = wr_fire;
    assign wr_addr               = wr_fire ? (obase_q + col_a * p_a + ADDR_W'(tx_cnt_q)) : '0;
    assign wr_data               = wr_fire ? opsum : '0;
    assign filter_valid          = out_vld && (state_q == S_FILTER);
    assign ifmap_valid           = out_vld && (state_q == S_IFMAP);
    assign depthwise_ipsum_valid = out_vld && (state_q == S_IPSUM);
    assign pointwise_ipsum_valid = out_vld && (state_q == S_PIPSUM);
    assign filter                = filter_valid          ? out_word : '0;
    assign ifmap                 = ifmap_valid           ? out_word : '0;
    assign depthwise_ipsum       = depthwise_ipsum_valid ? out_word : '0;
    assign pointwise_ipsum       = pointwise_ipsum_valid ? out_word : '0;
endmodule
`default_nettype wire

// File: tb/tb_pe_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pe_stream_ctrl
//  Purpose  : Directed self-checking bench for pe_stream_ctrl.
//  Revision : 1.0
// ============================================================================
module tb_pe_stream_ctrl;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int CW = 13;
    localparam logic [CW-1:0] CFG_ND  = 13'h0887;  // p=2 q=4 rs=3 F=1
    localparam logic [CW-1:0] CFG_DW  = 13'h1801;  // dw, p=1 q=2 rs=3 F=0
    localparam logic [CW-1:0] CFG_PR8 = 13'h0C80;  // p=2 rs=4 F=0
    localparam logic [AW-1:0] FB = 12'h100, IB = 12'h200, PB = 12'h300, OB = 12'h400;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start;
    logic [CW-1:0] cfg;
    logic [AW-1:0] filter_base, ifmap_base, ipsum_base, opsum_base;
    logic busy, done, rd_en, wr_en, PE_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] rd_data, wr_data, opsum;
    logic [CW-1:0] i_config;
    logic [DW-1:0] filter, ifmap, depthwise_ipsum, pointwise_ipsum;
    logic filter_valid, ifmap_valid, depthwise_ipsum_valid, pointwise_ipsum_valid;
    logic filter_ready, ifmap_ready, depthwise_ipsum_ready, pointwise_ipsum_ready;
    logic opsum_valid, opsum_ready;
    logic rnd_en;

    pe_stream_ctrl #(.ADDR_W(AW), .DATA_BITS(DW), .CONFIG_SIZE(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg(cfg),
        .filter_base(filter_base), .ifmap_base(ifmap_base),
        .ipsum_base(ipsum_base), .opsum_base(opsum_base),
        .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .PE_en(PE_en), .i_config(i_config),
        .filter(filter), .filter_valid(filter_valid), .filter_ready(filter_ready),
        .ifmap(ifmap), .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready),
        .depthwise_ipsum(depthwise_ipsum), .depthwise_ipsum_valid(depthwise_ipsum_valid),
        .depthwise_ipsum_ready(depthwise_ipsum_ready),
        .pointwise_ipsum(pointwise_ipsum), .pointwise_ipsum_valid(pointwise_ipsum_valid),
        .pointwise_ipsum_ready(pointwise_ipsum_ready),
        .opsum(opsum), .opsum_valid(opsum_valid), .opsum_ready(opsum_ready)
    );

    // Buffer model: every word carries its own address in the low 12 bits.
    always @(posedge clk) if (rd_en) rd_data <= {20'hA5A5A, rd_addr};

    // Ready/opsum driver: filter/ifmap ready go random when rnd_en is set.
    initial begin
        filter_ready = 1'b1;
        ifmap_ready  = 1'b1;
        opsum        = 32'h0B00_0000;
        forever begin
            @(negedge clk);
            filter_ready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
            ifmap_ready  = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
            opsum        = opsum + 32'd1;
        end
    end

    logic [DW-1:0] cap_f[$], cap_i[$], cap_d[$], cap_p[$];
    logic [AW-1:0] cap_wa[$];
    logic [DW-1:0] cap_wd[$], cap_op[$];
    int rd_runs[$], fv_runs[$];
    int n_done = 0, n_pe = 0, n_stab = 0, rd_run = 0, fv_run = 0;
    logic [3:0]    stall = '0;
    logic [DW-1:0] sdat [4];
    logic [3:0]    vld_v, rdy_v;
    logic [DW-1:0] dat_v [4];
    assign vld_v = {pointwise_ipsum_valid, depthwise_ipsum_valid, ifmap_valid, filter_valid};
    assign rdy_v = {pointwise_ipsum_ready, depthwise_ipsum_ready, ifmap_ready, filter_ready};
    assign dat_v[0] = filter;
    assign dat_v[1] = ifmap;
    assign dat_v[2] = depthwise_ipsum;
    assign dat_v[3] = pointwise_ipsum;

    always @(posedge clk) begin
        int viol;
        viol = 0;
        if (filter_valid && filter_ready)                   cap_f.push_back(filter);
        if (ifmap_valid && ifmap_ready)                     cap_i.push_back(ifmap);
        if (depthwise_ipsum_valid && depthwise_ipsum_ready) cap_d.push_back(depthwise_ipsum);
        if (pointwise_ipsum_valid && pointwise_ipsum_ready) cap_p.push_back(pointwise_ipsum);
        if (wr_en) begin
            cap_wa.push_back(wr_addr);
            cap_wd.push_back(wr_data);
            cap_op.push_back(opsum);
        end
        if (done)  n_done <= n_done + 1;
        if (PE_en) n_pe   <= n_pe + 1;
        if (rd_en) rd_run <= rd_run + 1;
        else if (rd_run != 0) begin rd_runs.push_back(rd_run); rd_run <= 0; end
        if (filter_valid) fv_run <= fv_run + 1;
        else if (fv_run != 0) begin fv_runs.push_back(fv_run); fv_run <= 0; end
        if (rst) begin
            stall <= '0;
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (stall[c] && (!vld_v[c] || dat_v[c] !== sdat[c])) viol++;
                sdat[c] <= dat_v[c];
            end
            stall  <= vld_v & ~rdy_v;
            n_stab <= n_stab + viol;
        end
    end

    int n_checks = 0, n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int cap_size(input int ch);
        case (ch)
            0: return cap_f.size();
            1: return cap_i.size();
            2: return cap_d.size();
            default: return cap_p.size();
        endcase
    endfunction

    function automatic logic [DW-1:0] cap_at(input int ch, input int idx);
        if (idx >= cap_size(ch)) return 32'hDEAD_DEAD;
        case (ch)
            0: return cap_f[idx];
            1: return cap_i[idx];
            2: return cap_d[idx];
            default: return cap_p[idx];
        endcase
    endfunction

    task automatic check_chan(input string tag, input int ch, input int from,
                              input logic [AW-1:0] a0, input int n);
        chk({tag, "_count"}, 64'(cap_size(ch) - from), 64'(n));
        for (int k = 0; k < n; k++)
            chk(tag, cap_at(ch, from + k), {20'hA5A5A, a0 + AW'(k)});
    endtask

    task automatic check_wr(input string tag, input int from, input logic [AW-1:0] a0, input int n);
        chk({tag, "_count"}, 64'(cap_wa.size() - from), 64'(n));
        for (int k = 0; k < n && from + k < cap_wa.size(); k++) begin
            chk({tag, "_addr"}, cap_wa[from + k], a0 + AW'(k));
            chk({tag, "_data"}, cap_wd[from + k], cap_op[from + k]);
        end
    endtask

    task automatic pulse_start(input logic [CW-1:0] c);
        cfg = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0; cfg = '0;
    endtask

    task automatic wait_done(input string tag, input int prev);
        int k;
        k = 0;
        while (n_done == prev && k < 2000) begin @(negedge clk); k++; end
        chk({tag, "_timeout"}, 64'(k < 2000), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_ctrl"}, {busy, done, PE_en, rd_en, wr_en, opsum_ready, vld_v}, '0);
        chk({tag, "_data"}, filter | ifmap | depthwise_ipsum | pointwise_ipsum | wr_data, '0);
        chk({tag, "_addr"}, {rd_addr, wr_addr, i_config}, '0);
    endtask

    int f0, i0, d0, p0, w0, nd0, np0, r0, v0, k;

    task automatic snap;
        f0 = cap_f.size(); i0 = cap_i.size(); d0 = cap_d.size(); p0 = cap_p.size();
        w0 = cap_wa.size(); nd0 = n_done; np0 = n_pe; r0 = rd_runs.size(); v0 = fv_runs.size();
    endtask

    task automatic check_nd_job(input string tag);
        check_chan({tag, "_filter"}, 0, f0, FB, 6);
        check_chan({tag, "_ifmap"},  1, i0, IB, 4);
        check_chan({tag, "_ipsum"},  2, d0, PB, 4);
        chk({tag, "_pipsum_none"}, 64'(cap_p.size() - p0), 64'd0);
        check_wr({tag, "_wr"}, w0, OB, 4);
        chk({tag, "_done_once"}, 64'(n_done - nd0), 64'd1);
        chk({tag, "_pe_en_once"}, 64'(n_pe - np0), 64'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg = '0; rnd_en = 1'b0;
        filter_base = FB; ifmap_base = IB; ipsum_base = PB; opsum_base = OB;
        depthwise_ipsum_ready = 1'b1; pointwise_ipsum_ready = 1'b1; opsum_valid = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Job 1: non-depthwise with continuous ready, plus start latency.
        snap();
        pulse_start(CFG_ND);
        chk("cfg_pe_en", {PE_en, busy}, 2'b11);
        chk("cfg_i_config", i_config, CFG_ND);
        @(negedge clk);
        chk("first_rd", {rd_en, rd_addr, filter_valid}, {1'b1, FB, 1'b0});
        @(negedge clk);
        chk("first_valid", {filter_valid, filter}, {1'b1, 20'hA5A5A, FB});
        wait_done("job1", nd0);
        check_nd_job("job1");
        chk("job1_busy_idle", busy, 1'b0);

        // Job 2: same config, random filter/ifmap ready.
        snap();
        rnd_en = 1'b1;
        pulse_start(CFG_ND);
        wait_done("job2", nd0);
        rnd_en = 1'b0;
        check_nd_job("job2");
        chk("job2_stable", 64'(n_stab), 64'd0);

        // Job 3: depthwise.
        snap();
        pulse_start(CFG_DW);
        wait_done("job3", nd0);
        check_chan("dw_filter",  0, f0, FB, 3);
        check_chan("dw_ifmap",   1, i0, IB, 3);
        check_chan("dw_ipsum",   2, d0, PB, 2);
        check_chan("dw_pipsum",  3, p0, PB + 12'd2, 4);
        check_wr("dw_wr", w0, OB, 1);
        chk("dw_done_once", 64'(n_done - nd0), 64'd1);

        // Job 4: P*R = 8 streams back to back.
        snap();
        pulse_start(CFG_PR8);
        wait_done("job4", nd0);
        check_chan("pr8_filter", 0, f0, FB, 8);
        chk("pr8_rd_run", 64'((rd_runs.size() > r0) ? rd_runs[r0] : -1), 64'd8);
        chk("pr8_fv_run", 64'((fv_runs.size() > v0) ? fv_runs[v0] : -1), 64'd8);
        check_wr("pr8_wr", w0, OB, 2);

        // Job 5: reset during the ipsum phase of column 1.
        snap();
        pulse_start(CFG_ND);
        k = 0;
        while (cap_d.size() < d0 + 3 && k < 2000) begin @(negedge clk); k++; end
        chk("midrst_reach", 64'(k < 2000), 64'd1);
        chk("midrst_in_ipsum", depthwise_ipsum_valid, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outs("midrst");
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("midrst_no_writes", 64'(cap_wa.size() - w0), 64'd2);
        chk("midrst_no_done", 64'(n_done - nd0), 64'd0);
        chk("midrst_idle", busy, 1'b0);
        snap();
        pulse_start(CFG_ND);
        wait_done("job5", nd0);
        check_nd_job("job5");

        // Job 6: start during OPSUM is ignored.
        snap();
        pulse_start(CFG_ND);
        k = 0;
        while (!opsum_ready && k < 2000) begin @(negedge clk); k++; end
        chk("ops_reach", 64'(k < 2000), 64'd1);
        pulse_start(CFG_DW);
        chk("ops_cfg_kept", i_config, CFG_ND);
        wait_done("job6", nd0);
        repeat (10) @(negedge clk);
        check_nd_job("job6");
        chk("job6_idle", busy, 1'b0);
        chk("job6_cfg_kept", i_config, CFG_ND);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
